hex_scroll_ctrl: RTL and testbench
==================================

Name: hex_scroll_ctrl

Overview:
Sequencer for the six DE10-Standard seven-segment displays (HEX5..HEX0). Holds a writable message buffer of up to 16 character codes. On a prescaled tick it scrolls a 6-character window across the buffer and drives the active-low segment patterns. Sits between user logic (switch/key handlers or a host writer) and the board HEX pins.

Parameters:
STEP_DIV, 25000000, clk cycles per scroll step (>=2); 0.5 s at 50 MHz
MAX_LEN, 16, buffer depth in characters; fixed power of two

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  4  buffer write index
wr_data  in  5  character code to write
msg_len  in  5  active message length 0..16; values >16 treated as 16
start  in  1  one-cycle pulse: begin scrolling
stop  in  1  one-cycle pulse: return to idle
pause  in  1  level: freeze scrolling while high
hex0..hex5  out  7 each  segment patterns, active-low, bit0=a .. bit6=g
busy  out  1  high in RUN or HOLD
step  out  1  one-cycle pulse when the window position advances

Behaviour:
- Reset (async, rst_n=0): state IDLE; pos=0; prescaler=0; all buffer entries=0x10 (blank); hex0..hex5=7'h7F; busy=0; step=0.
- Character codes: 0x00-0x0F hex digits 0-F (b, d lowercase); 0x10 blank; 0x11 H; 0x12 L; 0x13 P; 0x14 U; 0x15 '-'; 0x16-0x1F blank.
- Buffer: wr_en writes wr_data at wr_addr on the clk edge in any state. A write is visible on the display on the second edge after it.
- FSM:
  - IDLE: pos=0, prescaler=0, all hex blank. start -> RUN.
  - RUN: prescaler counts 0..STEP_DIV-1 and wraps. On the wrap cycle pos <= (pos+1) mod L, and step=1 for that cycle. pause=1 -> HOLD.
  - HOLD: prescaler and pos frozen; display still driven. pause=0 -> RUN, with the prescaler resuming its count.
  - stop in any state -> IDLE. stop has priority over start and pause when asserted in the same cycle. start in RUN/HOLD is ignored.
- Display window (RUN/HOLD), with L = clamped msg_len:
  - hex5 shows buf[pos], hex4 shows buf[(pos+1) mod L], ..., hex0 shows buf[(pos+5) mod L].
  - L=0: all blank, pos held at 0, step never asserts.
  - L=1: all six digits show buf[0]. step still pulses; pos stays 0.
- Outputs are registered: hex updates one edge after pos changes. Latency from the start pulse to the first valid display is 2 edges.
- msg_len change while running: if pos >= new L, pos <= 0 on the next edge. The modulo uses the new L immediately.
- busy is registered from the state.

Decomposition:
- Package hex_scroll_pkg: state enum (IDLE, RUN, HOLD), character code constants, BLANK_SEG=7'h7F, and the glyph function (5-bit code -> 7-bit active-low segments).
- One sub-module, hex_glyph_rom: combinational code-to-segment lookup, instantiated six times.

Test Plan (STEP_DIV=4):
- Reset: assert rst_n=0 mid-run -> hex0..5=7'h7F, busy=0 immediately (asynchronous); after release, state IDLE.
- HELLO: write 0x11,0x0E,0x12,0x12,0x00 to addr 0..4, msg_len=5, pulse start -> 2 edges later hex5=7'b0001001, hex4=7'b0000110, hex3=hex2=7'b1000111, hex1=7'b1000000, hex0=7'b0001001. step pulses every 4 cycles. After 5 steps pos=0 and the pattern repeats.
- Pause: pause=1 for 10 cycles during RUN -> hex and pos unchanged, no step, busy=1. After release, next step arrives after the remaining prescaler count.
- Start and stop in the same cycle while in RUN -> IDLE next edge; busy=0; hex blank one edge later.
- msg_len=0 with start -> busy=1, all hex 7'h7F, no step.
- Shrink: at pos=4, set msg_len 5->3 -> pos=0 next edge; hex5 shows buf[0].
- Write during run: write 0x15 to addr 0 -> '-' (7'b0111111) appears on every digit mapping to buf[0] after 2 edges.

Source files
------------

// File: rtl/hex_scroll_pkg.sv
// Shared types, character codes and the code-to-segment mapping for the
// six-digit HEX scroll controller.
package hex_scroll_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int N_DIGITS = 6;

   localparam logic [4:0] CH_BLANK = 5'h10;
   localparam logic [4:0] CH_H     = 5'h11;
   localparam logic [4:0] CH_L     = 5'h12;
   localparam logic [4:0] CH_P     = 5'h13;
   localparam logic [4:0] CH_U     = 5'h14;
   localparam logic [4:0] CH_DASH  = 5'h15;

   localparam logic [6:0] BLANK_SEG = 7'h7F;

   // Active-low segments, bit0 = a .. bit6 = g; unknown codes render blank.
   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] seg;
      case (code)
         5'h00:   seg = 7'b1000000;
         5'h01:   seg = 7'b1111001;
         5'h02:   seg = 7'b0100100;
         5'h03:   seg = 7'b0110000;
         5'h04:   seg = 7'b0011001;
         5'h05:   seg = 7'b0010010;
         5'h06:   seg = 7'b0000010;
         5'h07:   seg = 7'b1111000;
         5'h08:   seg = 7'b0000000;
         5'h09:   seg = 7'b0010000;
         5'h0A:   seg = 7'b0001000;
         5'h0B:   seg = 7'b0000011;
         5'h0C:   seg = 7'b1000110;
         5'h0D:   seg = 7'b0100001;
         5'h0E:   seg = 7'b0000110;
         5'h0F:   seg = 7'b0001110;
         CH_H:    seg = 7'b0001001;
         CH_L:    seg = 7'b1000111;
         CH_P:    seg = 7'b0001100;
         CH_U:    seg = 7'b1000001;
         CH_DASH: seg = 7'b0111111;
         default: seg = BLANK_SEG;
      endcase
      return seg;
   endfunction

   // (pos + ofs) mod len; pos may briefly exceed len right after a shrink.
   function automatic logic [3:0] wrap_idx(input logic [3:0] pos,
                                           input logic [2:0] ofs,
                                           input logic [4:0] len);
      logic [4:0] sum;
      sum = {1'b0, pos} + {2'b00, ofs};
      if (len == 5'd0) return 4'd0;
      return 4'(sum % len);
   endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational character-code to active-low seven-segment lookup.
module hex_glyph_rom
   import hex_scroll_pkg::*;
(
   input  logic [4:0] i_code,
   output logic [6:0] o_seg
);

   assign o_seg = glyph(i_code);

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a 6-character window across a writable 16-entry message buffer and
// drives the DE10-Standard HEX5..HEX0 displays (active-low segments).
module hex_scroll_ctrl
   import hex_scroll_pkg::*;
#(
   parameter int STEP_DIV = 25000000,
   parameter int MAX_LEN  = 16
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [4:0] wr_data,
   input  logic [4:0] msg_len,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3,
   output logic [6:0] hex4,
   output logic [6:0] hex5,
   output logic       busy,
   output logic       step
);

   localparam int              PW        = $clog2(STEP_DIV);
   localparam logic [PW-1:0]   PRESC_MAX = PW'(STEP_DIV - 1);
   localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
   localparam logic [4:0]      LEN_MAX   = 5'(MAX_LEN);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [3:0]    r_pos;
   logic [4:0]    r_buf [MAX_LEN];
   logic [6:0]    r_hex [N_DIGITS];
   logic          r_busy;
   logic          r_step;

   logic [4:0]    w_len;
   logic          w_active;
   logic          w_cnt_en;
   logic          w_wrap;
   logic          w_pos_oob;
   logic          w_adv;
   logic [4:0]    w_pos_inc;
   logic [4:0]    w_code [N_DIGITS];
   logic [6:0]    w_seg  [N_DIGITS];

   assign w_len = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // stop outranks start and pause; start is ignored once scrolling.
   always_comb begin
      // NOTE: default first so every path assigns it and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start && !stop) w_state_nxt = RUN;
         RUN: begin
            if (stop)       w_state_nxt = IDLE;
            else if (pause) w_state_nxt = HOLD;
         end
         HOLD: begin
            if (stop)        w_state_nxt = IDLE;
            else if (!pause) w_state_nxt = RUN;
         end
         default:            w_state_nxt = IDLE;
      endcase
   end

   // pause freezes the prescaler in the same cycle it is seen.
   always_comb begin
      w_active  = (r_state != IDLE);
      w_cnt_en  = (r_state == RUN) && !pause && !stop;
      w_wrap    = w_cnt_en && (r_presc == PRESC_MAX);
      w_pos_oob = ({1'b0, r_pos} >= w_len);
      w_adv     = w_wrap && !w_pos_oob;
      w_pos_inc = {1'b0, r_pos} + 5'd1;
      for (int d = 0; d < N_DIGITS; d++) begin
         w_code[d] = r_buf[wrap_idx(r_pos, 3'(N_DIGITS - 1 - d), w_len)];
      end
   end

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_rom
      hex_glyph_rom u_rom (
         .i_code (w_code[g]),
         .o_seg  (w_seg[g])
      );
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_pos   <= '0;
         r_step  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_step <= w_adv;
         r_busy <= (w_state_nxt != IDLE);
         if (w_state_nxt == IDLE) begin
            r_presc <= '0;
            r_pos   <= '0;
         end else begin
            if (w_cnt_en) r_presc <= w_wrap ? '0 : r_presc + PRESC_ONE;
            if (w_pos_oob)  r_pos <= '0;
            else if (w_adv) r_pos <= (w_pos_inc == w_len) ? 4'd0 : w_pos_inc[3:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < N_DIGITS; d++) r_hex[d] <= BLANK_SEG;
      end else begin
         for (int d = 0; d < N_DIGITS; d++) begin
            r_hex[d] <= (w_active && (w_len != 5'd0)) ? w_seg[d] : BLANK_SEG;
         end
      end
   end

   // NOTE: the buffer is reset on purpose so a fresh run shows blanks, not junk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= CH_BLANK;
      end else if (wr_en) begin
         r_buf[wr_addr] <= wr_data;
      end
   end

   assign hex0 = r_hex[0];
   assign hex1 = r_hex[1];
   assign hex2 = r_hex[2];
   assign hex3 = r_hex[3];
   assign hex4 = r_hex[4];
   assign hex5 = r_hex[5];
   assign busy = r_busy;
   assign step = r_step;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Scoreboard bench for hex_scroll_ctrl: stimulus queues expected display
// frames with their cycle stamps; a monitor pops one per observed change.
module tb_hex_scroll_ctrl;

   typedef struct packed {
      logic       st;
      logic       bz;
      logic [6:0] h5, h4, h3, h2, h1, h0;
   } snap_t;

   localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [4:0] wr_data;
   logic [4:0] msg_len;
   logic       start, stop, pause;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
   logic       busy, step;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   snap_t exp_q[$];
   int    exp_cyc_q[$];
   snap_t prev = {1'b0, 1'b0, {6{7'h7F}}};
   logic [4:0] m_buf [16];

   hex_scroll_ctrl #(.STEP_DIV(4), .MAX_LEN(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .msg_len (msg_len),
      .start   (start),
      .stop    (stop),
      .pause   (pause),
      .hex0    (hex0),
      .hex1    (hex1),
      .hex2    (hex2),
      .hex3    (hex3),
      .hex4    (hex4),
      .hex5    (hex5),
      .busy    (busy),
      .step    (step)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg_ref(input logic [4:0] c);
      case (c)
         5'h00: return 7'b1000000;
         5'h01: return 7'b1111001;
         5'h02: return 7'b0100100;
         5'h03: return 7'b0110000;
         5'h04: return 7'b0011001;
         5'h05: return 7'b0010010;
         5'h06: return 7'b0000010;
         5'h07: return 7'b1111000;
         5'h08: return 7'b0000000;
         5'h09: return 7'b0010000;
         5'h0A: return 7'b0001000;
         5'h0B: return 7'b0000011;
         5'h0C: return 7'b1000110;
         5'h0D: return 7'b0100001;
         5'h0E: return 7'b0000110;
         5'h0F: return 7'b0001110;
         5'h11: return 7'b0001001;
         5'h12: return 7'b1000111;
         5'h13: return 7'b0001100;
         5'h14: return 7'b1000001;
         5'h15: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // Frame with hex5 = buf[pos], hex0 = buf[(pos+5) mod len].
   function automatic snap_t win(input logic st, input logic bz, input int pos, input int len);
      logic [6:0] h [6];
      snap_t s;
      for (int d = 0; d < 6; d++) begin
         if (len == 0) h[d] = 7'h7F;
         else          h[d] = seg_ref(m_buf[(pos + 5 - d) % len]);
      end
      s = {st, bz, h[5], h[4], h[3], h[2], h[1], h[0]};
      return s;
   endfunction

   function automatic snap_t blank_s(input logic st, input logic bz);
      snap_t s;
      s = {st, bz, ALL_BLANK};
      return s;
   endfunction

   task automatic push(input int c, input snap_t s);
      exp_cyc_q.push_back(c);
      exp_q.push_back(s);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [4:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick(1);
      wr_en = 1'b0;
      m_buf[a] = d;
   endtask

   // Monitor: every change of {step, busy, hex5..hex0} must match the next queued frame.
   always @(negedge clk) begin
      snap_t cur;
      snap_t e;
      int    c;
      cur = {step, busy, hex5, hex4, hex3, hex2, hex1, hex0};
      if (cur != prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur);
         end else begin
            e = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            if (cur != e || cyc != c) begin
               errors++;
               $display("FAIL event cyc=%0d got=%h required cyc=%0d frame=%h", cyc, cur, c, e);
            end
         end
         prev = cur;
      end
   end

   initial begin
      int s, t, y, v;
      for (int i = 0; i < 16; i++) m_buf[i] = 5'h10;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      msg_len = '0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_step", 64'(step), 64'd0);
      check("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));

      // HELLO
      wr(4'd0, 5'h11); wr(4'd1, 5'h0E); wr(4'd2, 5'h12); wr(4'd3, 5'h12); wr(4'd4, 5'h00);
      msg_len = 5'd5;
      tick(1);
      check("idle_hex_after_writes", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));
      s = cyc;
      push(s + 1, blank_s(1'b0, 1'b1));
      push(s + 2, win(1'b0, 1'b1, 0, 5));
      for (int j = 1; j <= 5; j++) begin
         push(s + 1 + 4 * j, win(1'b1, 1'b1, j - 1, 5));
         push(s + 2 + 4 * j, win(1'b0, 1'b1, j % 5, 5));
      end
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      check("hello_frame", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
            64'({7'b0001001, 7'b0000110, 7'b1000111, 7'b1000111, 7'b1000000, 7'b0001001}));
      tick(21);

      // Pause for 10 cycles with the prescaler at 2
      for (int j = 0; j < 4; j++) begin
         push(s + 36 + 4 * j, win(1'b1, 1'b1, j, 5));
         push(s + 37 + 4 * j, win(1'b0, 1'b1, j + 1, 5));
      end
      pause = 1'b1;
      tick(5);
      check("pause_busy", 64'(busy), 64'd1);
      check("pause_step", 64'(step), 64'd0);
      tick(5);
      pause = 1'b0;
      tick(16);

      // Shrink 5 -> 3 at pos 4
      msg_len = 5'd3;
      push(s + 50, win(1'b0, 1'b1, 4, 3));
      push(s + 51, win(1'b0, 1'b1, 0, 3));
      push(s + 52, win(1'b1, 1'b1, 0, 3));
      push(s + 53, win(1'b0, 1'b1, 1, 3));
      tick(2);
      check("shrink_hex5_buf0", 64'(hex5), 64'(7'b0001001));
      tick(2);

      // Write '-' to addr 0 while running
      wr(4'd0, 5'h15);
      push(s + 55, win(1'b0, 1'b1, 1, 3));
      push(s + 56, win(1'b1, 1'b1, 1, 3));
      push(s + 57, win(1'b0, 1'b1, 2, 3));
      tick(1);
      check("write_run_hex3", 64'(hex3), 64'(7'b0111111));
      check("write_run_hex0", 64'(hex0), 64'(7'b0111111));
      tick(2);

      // start and stop together in RUN
      push(s + 58, win(1'b0, 1'b0, 2, 3));
      push(s + 59, blank_s(1'b0, 1'b0));
      start = 1'b1; stop = 1'b1;
      tick(1);
      start = 1'b0; stop = 1'b0;
      check("stop_busy", 64'(busy), 64'd0);
      tick(1);
      check("stop_hex_blank", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));

      // msg_len = 0
      msg_len = 5'd0;
      t = cyc;
      push(t + 1, blank_s(1'b0, 1'b1));
      push(t + 14, blank_s(1'b0, 1'b0));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(12);
      check("len0_busy", 64'(busy), 64'd1);
      check("len0_hex_blank", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(1);

      // msg_len = 1, then asynchronous reset mid-run
      msg_len = 5'd1;
      y = cyc;
      push(y + 1, blank_s(1'b0, 1'b1));
      push(y + 2, win(1'b0, 1'b1, 0, 1));
      push(y + 5, win(1'b1, 1'b1, 0, 1));
      push(y + 6, win(1'b0, 1'b1, 0, 1));
      push(y + 9, win(1'b1, 1'b1, 0, 1));
      push(y + 10, win(1'b0, 1'b1, 0, 1));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(10);
      check("len1_all_dash", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'b0111111}}));
      push(cyc, blank_s(1'b0, 1'b0));
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));
      for (int i = 0; i < 16; i++) m_buf[i] = 5'h10;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("post_rst_idle_busy", 64'(busy), 64'd0);

      // Buffer was cleared by reset: a run shows only blanks
      msg_len = 5'd5;
      v = cyc;
      push(v + 1, blank_s(1'b0, 1'b1));
      push(v + 5, blank_s(1'b1, 1'b1));
      push(v + 6, blank_s(1'b0, 1'b1));
      push(v + 8, blank_s(1'b0, 1'b0));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(6);
      check("buf_reset_blank", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(3);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
